// File: rtl/janela_3x3.sv
// -----------------------------------------------------------------------------
// janela_3x3 -- 3x3 sliding-window generator for a raster-order 8-bit stream.
//
// Two line memories hold the previous two image rows. Each accepted pixel
// pushes a new right-hand column {row-2, row-1, current} into a 3x3 shift
// register. A window is published only when the accepted pixel sits at
// row>=2 and col>=2, so a window never straddles a row or frame boundary.
// Stale line-memory content is harmless for the same reason.
//
// Parameters
//   IMG_WIDTH        pixels per row   (>=3)
//   IMG_HEIGHT       rows per frame   (>=3)
// Ports
//   clk_in           clock, rising edge
//   rst_in           asynchronous, active-high reset
//   pixel_in[7:0]    grayscale pixel, raster order
//   pixel_valid_in   pixel_in accepted on this edge; low freezes all state
//   sof_in           start of frame, qualified by pixel_valid_in
//   window_out[71:0] 3x3 window, byte i = 3*r + k (r=0 top row, k=0 left col);
//                    byte 8 newest pixel, byte 4 centre. Holds while not valid.
//                    Drives a downstream 72-bit pixel_data_in / valid pair.
//   window_valid_out one-cycle pulse per window
//   frame_done_out   one-cycle pulse after the last pixel of a frame
// -----------------------------------------------------------------------------
module janela_3x3 #(
    parameter int IMG_WIDTH  = 160,
    parameter int IMG_HEIGHT = 120
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [7:0]  pixel_in,
    input  logic        pixel_valid_in,
    input  logic        sof_in,
    output logic [71:0] window_out,
    output logic        window_valid_out,
    output logic        frame_done_out
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(2);
    localparam logic [RW-1:0] ROW_MIN  = RW'(2);

    // Position counters and registered outputs
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [71:0]   r_shift;
    logic [71:0]   r_window;
    logic          r_valid;
    logic          r_done;

    // Line memories: lb0 = previous row, lb1 = row before that (no reset needed)
    logic [7:0]    r_lb0 [0:IMG_WIDTH-1];
    logic [7:0]    r_lb1 [0:IMG_WIDTH-1];

    logic          w_accept;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic [CW-1:0] w_col_nxt;
    logic [RW-1:0] w_row_nxt;
    logic [7:0]    w_lb0_rd;
    logic [7:0]    w_lb1_rd;
    logic [71:0]   w_shift_nxt;
    logic          w_win_hit;
    logic          w_last_pix;

    // Position of the pixel being accepted, next counters and next window column
    always_comb begin
        w_accept   = pixel_valid_in;
        w_col      = r_col;
        w_row      = r_row;
        w_col_nxt  = r_col;
        w_row_nxt  = r_row;

        // sof forces this pixel to (0,0) regardless of where the counters are
        if (pixel_valid_in && sof_in) begin
            w_col = '0;
            w_row = '0;
        end else begin
            w_col = r_col;
            w_row = r_row;
        end

        // Pre-update memory values feed the new column
        w_lb0_rd = r_lb0[w_col];
        w_lb1_rd = r_lb1[w_col];

        // Each row of bytes moves one column left; the new right column enters
        // as {lb1, lb0, pixel} top to bottom (bytes 2, 5, 8).
        w_shift_nxt = {pixel_in, r_shift[71:56],
                       w_lb0_rd, r_shift[47:32],
                       w_lb1_rd, r_shift[23:8]};

        w_win_hit  = (w_row >= ROW_MIN) && (w_col >= COL_MIN);
        w_last_pix = (w_col == COL_LAST) && (w_row == ROW_LAST);

        if (w_col == COL_LAST) begin
            w_col_nxt = '0;
            if (w_row == ROW_LAST) begin
                w_row_nxt = '0;
            end else begin
                w_row_nxt = w_row + RW'(1);
            end
        end else begin
            w_col_nxt = w_col + CW'(1);
            w_row_nxt = w_row;
        end
    end

    // Counters, window shift register and output pulses
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_col    <= '0;
            r_row    <= '0;
            r_shift  <= '0;
            r_window <= '0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
        end else if (w_accept) begin
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_shift <= w_shift_nxt;
            r_valid <= w_win_hit;
            r_done  <= w_last_pix;
            // Published window only changes with a valid pulse, otherwise held
            if (w_win_hit) begin
                r_window <= w_shift_nxt;
            end else begin
                r_window <= r_window;
            end
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end
    end

    // Line-memory update: the old row-1 byte moves down to row-2
    always_ff @(posedge clk_in) begin
        if (w_accept) begin
            r_lb1[w_col] <= w_lb0_rd;
            r_lb0[w_col] <= pixel_in;
        end
    end

    assign window_out       = r_window;
    assign window_valid_out = r_valid;
    assign frame_done_out   = r_done;

endmodule

// File: tb/tb_janela_3x3.sv
// -----------------------------------------------------------------------------
// tb_janela_3x3 -- directed bench for janela_3x3 with a 4x4 image where the
// pixel at (r,c) is 16*r+c. Expected windows come from the coordinates of the
// bottom-right pixel, independent of how the design builds them.
// -----------------------------------------------------------------------------
module tb_janela_3x3;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [7:0]  pixel_in;
    logic        pixel_valid_in;
    logic        sof_in;
    logic [71:0] window_out;
    logic        window_valid_out;
    logic        frame_done_out;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_win    = 0;
    logic [71:0] exp_win  = 72'd0;

    janela_3x3 #(
        .IMG_WIDTH (4),
        .IMG_HEIGHT(4)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .pixel_in        (pixel_in),
        .pixel_valid_in  (pixel_valid_in),
        .sof_in          (sof_in),
        .window_out      (window_out),
        .window_valid_out(window_valid_out),
        .frame_done_out  (frame_done_out)
    );

    always #5 clk_in = ~clk_in;

    // Window whose bottom-right pixel is (r,c)
    function automatic logic [71:0] model_window(input int r, input int c);
        logic [71:0] w;
        w = 72'd0;
        for (int rr = 0; rr < 3; rr++) begin
            for (int k = 0; k < 3; k++) begin
                w[(3*rr+k)*8 +: 8] = 8'(16*(r-2+rr) + (c-2+k));
            end
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drive one cycle, then check outputs #1 after the edge
    task automatic step(input logic v, input logic s, input logic [7:0] p,
                        input logic ev, input logic ed, input logic [71:0] ew);
        pixel_valid_in = v;
        sof_in         = s;
        pixel_in       = p;
        @(posedge clk_in);
        #1;
        if (ev) exp_win = ew;
        chk("window_valid", {71'd0, window_valid_out}, {71'd0, ev});
        chk("frame_done", {71'd0, frame_done_out}, {71'd0, ed});
        chk("window_out", window_out, exp_win);
        if (window_valid_out) n_win++;
        pixel_valid_in = 1'b0;
        sof_in         = 1'b0;
    endtask

    // Raster indices first..last; toggle inserts an idle cycle (with a stray sof)
    task automatic run_pixels(input int first, input int last, input bit sof_first, input bit toggle);
        for (int idx = first; idx <= last; idx++) begin
            int r;
            int c;
            r = idx / 4;
            c = idx % 4;
            step(1'b1, (sof_first && idx == first), 8'(16*r + c),
                 (r >= 2 && c >= 2), (r == 3 && c == 3), model_window(r, c));
            if (toggle) step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 72'd0);
        end
    endtask

    initial begin
        rst_in         = 1'b0;
        pixel_in       = 8'd0;
        pixel_valid_in = 1'b0;
        sof_in         = 1'b0;
        #2 rst_in = 1'b1;
        #1;
        chk("reset_window", window_out, 72'd0);
        chk("reset_valid", {71'd0, window_valid_out}, 72'd0);
        chk("reset_done", {71'd0, frame_done_out}, 72'd0);
        @(posedge clk_in);
        @(posedge clk_in);
        #1 rst_in = 1'b0;

        // Continuous frame with sof; first window after 0x22, last after 0x33
        n_win = 0;
        run_pixels(0, 15, 1'b1, 1'b0);
        chk("frame1_windows", 72'(n_win), 72'd4);
        chk("first_window", model_window(2, 2), 72'h22_21_20_12_11_10_02_01_00);
        chk("last_window", model_window(3, 3), 72'h33_32_31_23_22_21_13_12_11);

        // Back-to-back frame with valid toggling; idle cycles carry sof
        n_win = 0;
        run_pixels(0, 15, 1'b1, 1'b1);
        chk("frame2_windows", 72'(n_win), 72'd4);

        // Another back-to-back continuous frame
        n_win = 0;
        run_pixels(0, 15, 1'b1, 1'b0);
        chk("frame3_windows", 72'(n_win), 72'd4);

        // Reset after pixel 0x21: outputs clear at once, no pulse follows
        run_pixels(0, 9, 1'b1, 1'b0);
        rst_in = 1'b1;
        #1;
        exp_win = 72'd0;
        chk("midreset_window", window_out, 72'd0);
        chk("midreset_valid", {71'd0, window_valid_out}, 72'd0);
        chk("midreset_done", {71'd0, frame_done_out}, 72'd0);
        @(posedge clk_in);
        #2 rst_in = 1'b0;
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 72'd0);

        // New frame after reset without sof starts at (0,0)
        n_win = 0;
        run_pixels(0, 15, 1'b0, 1'b0);
        chk("postreset_windows", 72'(n_win), 72'd4);

        // sof at (1,3) abandons the frame; the restarted frame is normal
        n_win = 0;
        run_pixels(0, 6, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 72'd0);
        run_pixels(1, 15, 1'b0, 1'b0);
        chk("abandon_windows", 72'(n_win), 72'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/janela_3x3.md
JANELA_3X3 -- requirements
Module: janela_3x3

Interface
REQ-001 Parameter IMG_WIDTH, default 160, pixels per image row (>=3).
REQ-002 Parameter IMG_HEIGHT, default 120, rows per frame (>=3).
REQ-003 clk_in  input  1  single clock; all logic on its rising edge.
REQ-004 rst_in  input  1  asynchronous, active-high reset.
REQ-005 pixel_in  input  8  raster-order grayscale pixel.
REQ-006 pixel_valid_in  input  1  pixel_in accepted on the current edge when high.
REQ-007 sof_in  input  1  start of frame; qualified by pixel_valid_in.
REQ-008 window_out  output  72  3x3 neighbourhood; byte i at bits [i*8+7:i*8].
REQ-009 window_valid_out  output  1  window_out is valid this cycle (one-cycle pulse per window).
REQ-010 frame_done_out  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-011 An accept SHALL occur on each edge with pixel_valid_in=1; no backpressure; pixel_valid_in=0 SHALL freeze all state.
REQ-012 Column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) SHALL give the position of the pixel being accepted.
REQ-013 After an accept, col SHALL increment; at IMG_WIDTH-1 it SHALL wrap to 0 and row SHALL increment; at (IMG_WIDTH-1, IMG_HEIGHT-1) both SHALL wrap to 0.
REQ-014 sof_in=1 with an accept SHALL treat that pixel as (0,0), overriding the counters; sof_in with pixel_valid_in=0 SHALL be ignored.
REQ-015 Two line memories of IMG_WIDTH bytes SHALL hold row-1 (lb0) and row-2 (lb1); on accept at column c: lb1[c]<=lb0[c], lb0[c]<=pixel_in.
REQ-016 The window register SHALL shift left by one column per accept; the new right column SHALL be {lb1[c], lb0[c], pixel_in}, top to bottom, using the pre-update memory values.
REQ-017 Byte ordering: i = 3*r + k, with r=0 the top row (row-2) and k=0 the leftmost column (col-2); byte 8 SHALL be the newest pixel; byte 4 SHALL be the centre (row-1, col-1).
REQ-018 window_valid_out SHALL go high on the edge after an accept with row>=2 and col>=2; window_out SHALL update on that same edge (latency 1 cycle).
REQ-019 A valid window SHALL never span a row or frame boundary; windows per frame SHALL be (IMG_WIDTH-2)*(IMG_HEIGHT-2).
REQ-020 window_out SHALL hold its last value while window_valid_out=0.
REQ-021 frame_done_out SHALL go high on the edge after the accept at (IMG_WIDTH-1, IMG_HEIGHT-1).
REQ-022 Stale line-memory content from a prior frame SHALL NOT produce a valid window; this is ensured by REQ-018 gating alone.
REQ-023 An sof_in arriving mid-frame SHALL abandon the current frame without a frame_done_out pulse.
REQ-024 window_out SHALL be suitable for direct connection to a 72-bit pixel_data_in / valid pair of the downstream convolution stage.

Reset
REQ-025 On rst_in=1, col, row, window register and outputs SHALL clear to 0 immediately, independent of clk_in.
REQ-026 Line memories SHALL NOT require reset.
REQ-027 After rst_in is released, the first accepted pixel SHALL be (0,0), whether or not sof_in is asserted.
REQ-028 Reset asserted mid-frame SHALL suppress any pending window_valid_out and frame_done_out pulses.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, pixel at (r,c) = 16*r+c)
REQ-029 Stream a full frame continuously with sof_in on the first pixel -> exactly 4 window_valid_out pulses; the first arrives one cycle after pixel 0x22. First window: byte0=0x00, byte4=0x11, byte8=0x22.
REQ-030 Same frame with pixel_valid_in toggling 1,0,1,0 -> identical window sequence and values; window_valid_out is never high on consecutive cycles.
REQ-031 End of frame -> frame_done_out pulses once, one cycle after pixel 0x33; the last window has byte0=0x11 and byte8=0x33.
REQ-032 Two back-to-back frames -> the second frame has no valid window before its pixel (2,2); it also yields 4 windows.
REQ-033 Assert rst_in after pixel 0x21 -> outputs are 0 that cycle; no pulse follows; a new frame then behaves as in REQ-029.
REQ-034 Assert sof_in with pixel_valid_in at pixel (1,3) -> the counters restart at (0,0); no frame_done_out occurs for the abandoned frame.
